// File: rtl/grid_dimensions.svh
// Board geometry shared by the tile array and the solver sequencer.
`ifndef GRID_DIMENSIONS_SVH
`define GRID_DIMENSIONS_SVH

`define GRID_LEN 4

`endif

// File: rtl/solver_sequencer.sv
// Backtracking turn sequencer: grants one tile at a time, walks forward on passfwd, back on passbak.
// Optional backtrack counter enabled by defining SEQ_BTCOUNT_EN.
`include "grid_dimensions.svh"

module solver_sequencer #(
    parameter  int unsigned GRID_LEN = `GRID_LEN,
    localparam int unsigned NTILES   = GRID_LEN * GRID_LEN,
    localparam int unsigned IW       = $clog2(NTILES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [NTILES-1:0] myturn,
    input  logic [NTILES-1:0] passfwd,
    input  logic [NTILES-1:0] passbak,
    output logic [IW-1:0]     curidx,
    output logic              busy,
    output logic              solved,
    output logic              unsolvable,
    output logic [15:0]       btcount
);

    localparam int unsigned BTW = 16;

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        ISSUE      = 5'b00010,
        AWAIT      = 5'b00100,
        SOLVED     = 5'b01000,
        UNSOLVABLE = 5'b10000
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IW-1:0]     curidx_next;
    logic [NTILES-1:0] myturn_next;
    logic              busy_next;
    logic              solved_next;
    logic              unsolvable_next;
    logic              bt_inc;
    logic              bt_clr;
    logic              fwd_hit;
    logic              bak_hit;

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            curidx     <= '0;
            myturn     <= '0;
            busy       <= 1'b0;
            solved     <= 1'b0;
            unsolvable <= 1'b0;
        end else begin
            state      <= state_next;
            curidx     <= curidx_next;
            myturn     <= myturn_next;
            busy       <= busy_next;
            solved     <= solved_next;
            unsolvable <= unsolvable_next;
        end
    end

    // Next state; only the current holder's pass bits are looked at, backtrack wins ties
    always_comb begin
        state_next      = state;
        curidx_next     = curidx;
        myturn_next     = '0;
        busy_next       = 1'b0;
        solved_next     = 1'b0;
        unsolvable_next = 1'b0;
        bt_inc          = 1'b0;
        bt_clr          = 1'b0;
        fwd_hit         = passfwd[curidx];
        bak_hit         = passbak[curidx];

        unique case (state)
            IDLE: begin
                if (start) begin
                    curidx_next = '0;
                    state_next  = ISSUE;
                    bt_clr      = 1'b1;
                end
            end
            ISSUE: state_next = AWAIT;
            AWAIT: begin
                if (bak_hit) begin
                    bt_inc = 1'b1;
                    if (curidx == '0) begin
                        state_next = UNSOLVABLE;
                    end else begin
                        curidx_next = curidx - IW'(1);
                        state_next  = ISSUE;
                    end
                end else if (fwd_hit) begin
                    if (curidx == IW'(NTILES - 1)) begin
                        state_next = SOLVED;
                    end else begin
                        curidx_next = curidx + IW'(1);
                        state_next  = ISSUE;
                    end
                end
            end
            SOLVED, UNSOLVABLE: state_next = state;
            default: begin
                state_next  = IDLE;
                curidx_next = '0;
            end
        endcase

        if (abort && (state != IDLE)) begin
            state_next  = IDLE;
            curidx_next = '0;
            bt_inc      = 1'b0;
            bt_clr      = 1'b0;
        end

        if (state_next == ISSUE) begin
            myturn_next[curidx_next] = 1'b1;
        end
        busy_next       = (state_next == ISSUE) || (state_next == AWAIT);
        solved_next     = (state_next == SOLVED);
        unsolvable_next = (state_next == UNSOLVABLE);
    end

`ifdef SEQ_BTCOUNT_EN
    // Saturating count of accepted backtracks since the last accepted start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btcount <= '0;
        end else if (bt_clr) begin
            btcount <= '0;
        end else if (bt_inc && (btcount != {BTW{1'b1}})) begin
            btcount <= btcount + BTW'(1);
        end
    end
`else
    logic unused_bt;
    assign unused_bt = bt_inc ^ bt_clr;
    assign btcount   = '0;
`endif

endmodule
